// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, default widths and the
// parity helpers used by both the transmit and receive sides.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_BAUD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    function automatic uart_parity_e parity_mode(input logic en, input logic odd);
        uart_parity_e mode;
        if (!en) begin
            mode = PAR_NONE;
        end else if (odd) begin
            mode = PAR_ODD;
        end else begin
            mode = PAR_EVEN;
        end
        return mode;
    endfunction

    // Zero-extension of narrower data leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [63:0] data, input uart_parity_e mode);
        logic p;
        p = ^data;
        case (mode)
            PAR_EVEN: p = p;
            PAR_ODD:  p = ~p;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// Transmit data shift register with bit counter: loads a byte and its parity,
// then shifts one bit towards the line on every shift request.
module uart_tx_shift
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_par_odd,
    input  logic              shift_en,
    output logic              cur_bit,
    output logic              nxt_bit,
    output logic              last_bit,
    output logic              par_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    uart_parity_e      load_mode_s;

    // Next-state: load has priority over shifting.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        load_mode_s = PAR_EVEN;
        if (load) begin
            if (load_par_odd) begin
                load_mode_s = PAR_ODD;
            end else begin
                load_mode_s = PAR_EVEN;
            end
            sr_d  = load_data;
            cnt_d = {CNT_W{1'b0}};
            par_d = parity_bit(64'(load_data), load_mode_s);
        end else if (shift_en) begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            sr_d  = sr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= {DATA_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            par_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    assign cur_bit  = sr_q[0];
    assign nxt_bit  = sr_q[1];
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
    assign par_bit  = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte as start/data/parity/stop bits,
// paced by bit ticks from an external clock generator it enables.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int BAUD_W = UART_BAUD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BAUD_W-1:0] cfg_baud,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              tx_clk_en,
    output logic              gen_active,
    output logic [BAUD_W-1:0] gen_baud,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    uart_state_e       state_q;
    uart_parity_e      par_q;
    logic              txd_q;
    logic              gen_active_q;
    logic [BAUD_W-1:0] gen_baud_q;
    logic              frame_done_q;
    logic              stop2_q;
    logic              stop_cnt_q;

    logic final_tick_s;
    logic accept_s;
    logic shift_en_s;
    logic cur_bit_s;
    logic nxt_bit_s;
    logic last_bit_s;
    logic par_bit_s;

    // Back-to-back acceptance is only safe when the generator keeps its rate.
    assign final_tick_s = (state_q == ST_STOP) && tx_clk_en && (!stop2_q || stop_cnt_q);
    assign tx_ready     = !rst && ((state_q == ST_IDLE) ||
                                   (final_tick_s && (cfg_baud == gen_baud_q)));
    assign accept_s     = tx_valid && tx_ready;
    assign shift_en_s   = (state_q == ST_DATA) && tx_clk_en && !last_bit_s;

    uart_tx_shift #(.DATA_W(DATA_W)) u_shift (
        .clk          (clk),
        .rst          (rst),
        .load         (accept_s),
        .load_data    (tx_data),
        .load_par_odd (cfg_parity_odd),
        .shift_en     (shift_en_s),
        .cur_bit      (cur_bit_s),
        .nxt_bit      (nxt_bit_s),
        .last_bit     (last_bit_s),
        .par_bit      (par_bit_s)
    );

    // Frame sequencer with registered line and generator controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            par_q        <= PAR_NONE;
            txd_q        <= 1'b1;
            gen_active_q <= 1'b0;
            gen_baud_q   <= {BAUD_W{1'b0}};
            frame_done_q <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
        end else begin
            frame_done_q <= final_tick_s;
            case (state_q)
                ST_IDLE: begin
                    gen_baud_q <= cfg_baud;
                    txd_q      <= 1'b1;
                    if (accept_s) begin
                        par_q        <= parity_mode(cfg_parity_en, cfg_parity_odd);
                        stop2_q      <= cfg_stop2;
                        gen_active_q <= 1'b1;
                        state_q      <= ST_ARM;
                    end else begin
                        gen_active_q <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (tx_clk_en) begin
                        state_q <= ST_START;
                        txd_q   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_clk_en) begin
                        state_q <= ST_DATA;
                        txd_q   <= cur_bit_s;
                    end
                end
                ST_DATA: begin
                    if (tx_clk_en) begin
                        if (!last_bit_s) begin
                            txd_q <= nxt_bit_s;
                        end else if (par_q != PAR_NONE) begin
                            state_q <= ST_PARITY;
                            txd_q   <= par_bit_s;
                        end else begin
                            state_q    <= ST_STOP;
                            txd_q      <= 1'b1;
                            stop_cnt_q <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tx_clk_en) begin
                        state_q    <= ST_STOP;
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (final_tick_s) begin
                        stop_cnt_q <= 1'b0;
                        if (accept_s) begin
                            par_q   <= parity_mode(cfg_parity_en, cfg_parity_odd);
                            stop2_q <= cfg_stop2;
                            state_q <= ST_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q      <= ST_IDLE;
                            gen_active_q <= 1'b0;
                            txd_q        <= 1'b1;
                        end
                    end else if (tx_clk_en) begin
                        stop_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    txd_q        <= 1'b1;
                    gen_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign txd        = txd_q;
    assign gen_active = gen_active_q;
    assign gen_baud   = gen_baud_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized frames
// compared against a bit-list model of the serial line.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cfg_baud;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_stop2;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_clk_en;
    logic       gen_active;
    logic [3:0] gen_baud;
    logic       txd;
    logic       busy;
    logic       frame_done;

    int errs   = 0;
    int checks = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_W(8), .BAUD_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_baud       (cfg_baud),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .tx_clk_en      (tx_clk_en),
        .gen_active     (gen_active),
        .gen_baud       (gen_baud),
        .txd            (txd),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference line model: start, data LSB first, optional parity, stop bit(s).
    function automatic void push_frame(input logic [7:0] d, input bit pe, input bit po, input bit s2);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ po);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endfunction

    // Hand-written line sequence, leftmost bit first on the wire.
    function automatic void push_vec(input logic [11:0] v, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v[n-1-i]);
    endfunction

    task automatic cyc(input logic en);
        tx_clk_en = en;
        @(posedge clk);
        #1;
        tx_clk_en = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) cyc(1'b0);
    endtask

    task automatic scramble_cfg();
        tx_data        = 8'($urandom);
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_stop2      = 1'($urandom);
    endtask

    task automatic accept(input logic [7:0] d, input bit pe, input bit po, input bit s2);
        tx_data = d; cfg_parity_en = pe; cfg_parity_odd = po; cfg_stop2 = s2;
        tx_valid = 1'b1;
        #1 chk("ready_idle", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        scramble_cfg();
        chk("arm_active", gen_active, 1'b1);
        chk("arm_busy", busy, 1'b1);
        repeat ($urandom_range(0, 2)) cyc(1'b0);
        chk("arm_txd", txd, 1'b1);
    endtask

    task automatic play(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            gap();
            cyc(1'b1);
            chk($sformatf("txd[%0d]", i), txd, exp_q[i]);
            chk("active_mid", gen_active, 1'b1);
            chk("done_early", frame_done, 1'b0);
        end
    endtask

    // Final stop tick, optionally offering the next byte in the same cycle.
    task automatic finish_frame(input bit chain, input logic [7:0] d2, input bit pe2,
                                input bit po2, input bit s22, input bit want_ready);
        gap();
        if (chain) begin
            tx_valid = 1'b1; tx_data = d2;
            cfg_parity_en = pe2; cfg_parity_odd = po2; cfg_stop2 = s22;
        end
        tx_clk_en = 1'b1;
        #1 chk("ready_last", tx_ready, want_ready);
        @(posedge clk);
        #1;
        tx_clk_en = 1'b0;
        chk("done_pulse", frame_done, 1'b1);
        if (chain && want_ready) begin
            tx_valid = 1'b0;
            scramble_cfg();
            chk("b2b_txd", txd, 1'b0);
            chk("b2b_active", gen_active, 1'b1);
            cyc(1'b0);
            chk("done_clear", frame_done, 1'b0);
        end else begin
            chk("end_txd", txd, 1'b1);
            chk("end_active", gen_active, 1'b0);
            chk("end_busy", busy, 1'b0);
            if (!chain) begin
                cyc(1'b0);
                chk("done_clear", frame_done, 1'b0);
            end
        end
    endtask

    initial begin
        logic [7:0] d, d2;
        bit         pe, po, s2, pe2, po2, s22, chain, from_idle;

        rst = 1'b1; cfg_baud = 4'd5; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        cfg_stop2 = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_active", gen_active, 1'b0);
        chk("rst_baud", gen_baud, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ready", tx_ready, 1'b0);
        cfg_baud = 4'd0;
        rst = 1'b0;
        #1 chk("ready_after_rst", tx_ready, 1'b1);
        cyc(1'b0);

        // 8N1 0xA5
        push_vec(12'b0101001011, 10);
        accept(8'hA5, 1'b0, 1'b0, 1'b0);
        play(0, 9);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // 8E1 and 8O1 0x07
        push_vec(12'b01110000011, 11);
        accept(8'h07, 1'b1, 1'b0, 1'b0);
        play(0, 10);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        push_vec(12'b01110000001, 11);
        accept(8'h07, 1'b1, 1'b1, 1'b0);
        play(0, 10);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // two stop bits
        push_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        accept(8'h3C, 1'b0, 1'b0, 1'b1);
        play(0, 10);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back 0x55 then 0xAA
        push_frame(8'h55, 1'b0, 1'b0, 1'b0);
        accept(8'h55, 1'b0, 1'b0, 1'b0);
        play(0, 9);
        finish_frame(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        push_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        play(1, 9);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // baud change mid-frame forces a pass through IDLE
        push_frame(8'h96, 1'b0, 1'b0, 1'b0);
        accept(8'h96, 1'b0, 1'b0, 1'b0);
        cfg_baud = 4'd3;
        play(0, 9);
        chk("baud_held", gen_baud, 4'd0);
        finish_frame(1'b1, 8'h69, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("baud_idle", gen_baud, 4'd0);
        cyc(1'b0);
        tx_valid = 1'b0;
        scramble_cfg();
        chk("baud_new", gen_baud, 4'd3);
        chk("baud_rearm", gen_active, 1'b1);
        push_frame(8'h69, 1'b1, 1'b0, 1'b0);
        play(0, 10);
        finish_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset while data bit 3 is on the line
        push_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        accept(8'hF0, 1'b0, 1'b0, 1'b0);
        play(0, 4);
        rst = 1'b1;
        cyc(1'b0);
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_active", gen_active, 1'b0);
        chk("mid_rst_ready", tx_ready, 1'b0);
        chk("mid_rst_baud", gen_baud, 4'd0);
        rst = 1'b0;
        cfg_baud = 4'd0;
        cyc(1'b0);
        chk("ready_release", tx_ready, 1'b1);

        // randomized frames, randomly chained back-to-back
        from_idle = 1'b1;
        d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); s2 = 1'($urandom);
        for (int n = 0; n < 10; n++) begin
            push_frame(d, pe, po, s2);
            if (from_idle) accept(d, pe, po, s2);
            play(from_idle ? 0 : 1, exp_q.size() - 1);
            chain = (n < 9) && ($urandom_range(0, 1) == 1);
            d2 = 8'($urandom); pe2 = 1'($urandom); po2 = 1'($urandom); s22 = 1'($urandom);
            finish_frame(chain, d2, pe2, po2, s22, 1'b1);
            if (!chain) begin
                for (int k = 0; k < 3; k++) begin
                    cyc(1'($urandom));
                    chk("idle_txd", txd, 1'b1);
                    chk("idle_busy", busy, 1'b0);
                end
            end
            from_idle = !chain;
            d = d2; pe = pe2; po = po2; s2 = s22;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame.
REQ-002 SHALL have parameter BAUD_W, default 4, width of the baud-rate index driven to clk_gen.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_baud  in  BAUD_W  requested baud index.
REQ-006 SHALL have port cfg_parity_en  in  1  parity bit appended when 1.
REQ-007 SHALL have port cfg_parity_odd  in  1  odd parity when 1, even when 0.
REQ-008 SHALL have port cfg_stop2  in  1  two stop bits when 1, one when 0.
REQ-009 SHALL have port tx_valid  in  1  byte offered.
REQ-010 SHALL have port tx_data  in  DATA_W  byte to send.
REQ-011 SHALL have port tx_ready  out  1  byte accepted when tx_valid && tx_ready.
REQ-012 SHALL have port tx_clk_en  in  1  bit-period tick from clk_gen.
REQ-013 SHALL have port gen_active  out  1  drives clk_gen active.
REQ-014 SHALL have port gen_baud  out  BAUD_W  drives clk_gen baud_rate.
REQ-015 SHALL have port txd  out  1  serial line, idle high.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  out  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-018 SHALL implement an FSM with states IDLE, ARM, START, DATA, PARITY and STOP.
REQ-019 IDLE: tx_ready=1, txd=1, gen_active=0, gen_baud registered from cfg_baud every cycle, tx_clk_en ignored.
REQ-020 On accept in IDLE SHALL latch tx_data and all cfg_* inputs, set gen_active=1 and enter ARM; later input changes SHALL not affect the frame.
REQ-021 ARM: txd=1; on first tx_clk_en SHALL enter START (phase alignment to the freshly activated clk_gen).
REQ-022 START drives txd=0; each subsequent tx_clk_en SHALL advance exactly one bit period.
REQ-023 DATA SHALL drive the latched bits LSB first for DATA_W ticks; a bit counter 0..DATA_W-1 SHALL select the bit.
REQ-024 PARITY (only when latched parity_en) SHALL drive XOR of the data bits, inverted when parity_odd.
REQ-025 STOP SHALL drive txd=1 for 1 tick, or 2 ticks when latched stop2.
REQ-026 On the final STOP tick SHALL pulse frame_done; with no new byte, SHALL return to IDLE with gen_active=0 the next cycle.
REQ-027 Back-to-back: tx_ready SHALL also be 1 combinationally in the final STOP tick cycle when cfg_baud == gen_baud; on accept there, SHALL go directly to START with gen_active held high and frame_done still pulsed.
REQ-028 If cfg_baud differs from gen_baud at the final STOP tick, tx_ready SHALL stay 0; the FSM SHALL pass through IDLE for at least one cycle with gen_active=0.
REQ-029 gen_baud SHALL change only while gen_active=0.
REQ-030 txd SHALL be registered, with no glitches between states.

Reset
REQ-031 While rst=1 the block SHALL hold IDLE with txd=1, gen_active=0, gen_baud=0, busy=0, frame_done=0 and tx_ready=0.
REQ-032 Reset mid-frame SHALL discard the byte, with txd=1 on the cycle after rst is sampled.
REQ-033 tx_ready SHALL rise on the first cycle after rst deasserts.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum, DATA_W/BAUD_W defaults and the parity-mode type, shared with the rx side.
REQ-035 Shift register plus bit counter SHALL be one sub-module, uart_tx_shift, with load, shift-on-tick and current-bit outputs.

Verification
REQ-036 8N1, send 0xA5 -> txd after ARM = 0,1,0,1,0,0,1,0,1,1 with one tick per bit; frame_done on the 10th tick.
REQ-037 8E1 with 0x07 -> parity bit 1; 8O1 with 0x07 -> parity bit 0; 11 ticks per frame.
REQ-038 0x55 then 0xAA held valid with baud unchanged -> gen_active never drops; second start bit on the tick after the first stop; two frame_done pulses.
REQ-039 cfg_baud 0->3 mid-frame -> gen_baud stays 0 until frame end; gen_active low at least 1 cycle; next frame gen_baud=3.
REQ-040 cfg_stop2=1 -> stop held 2 ticks; frame_done only on the second.
REQ-041 rst during DATA bit 3 -> next cycle txd=1, busy=0, gen_active=0; tx_ready=1 the cycle after release.
